cache_ctrl: RTL

Sequencing controller for the set-associative data cache. Accepts one trace command at a time and performs tag lookup across all ways. Picks the hit way or the allocation victim, applies the MESI next-state rule, and updates true-LRU ages. It also emits the L2 bus message and eviction writeback, and keeps hit/miss statistics. It sits between the trace reader and the L2/bus model and owns the tag, MESI and LRU arrays.

---
 rtl/cache_ctrl_pkg.sv | 41 ++++
 rtl/cache_ctrl_mesi.sv | 48 ++++
 rtl/cache_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the data-cache sequencing controller.
package my_struct_package;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [3:0] {
    CMD_READ   = 4'd0,
    CMD_WRITE  = 4'd1,
    CMD_IFETCH = 4'd2,
    CMD_INVAL  = 4'd3,
    CMD_SNOOP  = 4'd4,
    CMD_CLEAR  = 4'd8,
    CMD_PRINT  = 4'd9
  } cmd_code_t;

  typedef enum logic [1:0] {
    L2_NONE  = 2'd0,
    L2_READ  = 2'd1,
    L2_RFO   = 2'd2,
    L2_INVAL = 2'd3
  } l2_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_UPDATE,
    ST_RESP,
    ST_CLEAR
  } ctrl_state_t;

  // Read, write and ifetch are the only commands that allocate, age and count.
  function automatic logic is_access(input logic [3:0] n);
    return (n <= 4'd2);
  endfunction

endpackage

// File: rtl/cache_ctrl_mesi.sv
// MESI next-state rule for the selected line (hit way or allocation victim).
module mesi_next_state
  import my_struct_package::*;
(
  input  mesi_t       cur,
  input  logic [3:0]  cmd,
  input  logic        hit,
  output mesi_t       nxt,
  output l2_op_t      op,
  output logic        wb
);

  // Default is "no change, no bus traffic"; each command overrides what it touches.
  always_comb begin
    nxt = cur;
    op  = L2_NONE;
    wb  = 1'b0;
    case (cmd)
      CMD_READ, CMD_IFETCH: begin
        if (!hit) begin
          nxt = MESI_E;
          op  = L2_READ;
          wb  = (cur == MESI_M);
        end
      end
      CMD_WRITE: begin
        nxt = MESI_M;
        if (hit) begin
          if (cur == MESI_S) op = L2_INVAL;
        end else begin
          op = L2_RFO;
          wb = (cur == MESI_M);
        end
      end
      CMD_INVAL: begin
        if (hit) nxt = MESI_I;
      end
      CMD_SNOOP: begin
        if (hit) begin
          nxt = MESI_S;
          wb  = (cur == MESI_M);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cache_ctrl.sv
// Set-associative cache controller: lookup, MESI update, true-LRU, bus message, stats.
module cache_ctrl
  import my_struct_package::*;
#(
  parameter int WAYS     = 4,
  parameter int SETS     = 16,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_n,
  input  logic [ADDR_W-1:0]       cmd_addr,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [$clog2(WAYS)-1:0] resp_way,
  output logic [1:0]              resp_mesi,
  output logic [1:0]              l2_op,
  output logic                    wb_valid,
  output logic [ADDR_W-1:0]       wb_addr,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  ctrl_state_t state, state_nxt;

  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q;
  mesi_t [SETS-1:0][WAYS-1:0]           mesi_q;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q;

  logic [3:0]               cmd_q;
  logic [ADDR_W-1:OFFSET_W] line_q;
  logic [IDX_W-1:0]         clr_idx;
  logic                     lk_hit;
  logic [WAY_W-1:0]         lk_way;

  logic                     r_hit, r_wb;
  logic [WAY_W-1:0]         r_way;
  mesi_t                    r_mesi;
  l2_op_t                   r_op;
  logic [ADDR_W-1:0]        r_wba;

  // Offset bits never matter to a line-granular controller.
  logic unused_offset;
  assign unused_offset = ^cmd_addr[OFFSET_W-1:0];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign idx = line_q[OFFSET_W +: IDX_W];
  assign tag = line_q[ADDR_W-1 -: TAG_W];

  // Tag compare across the set; victim is lowest invalid way, else the oldest.
  logic             hit_c;
  logic [WAY_W-1:0] sel_way_c;
  always_comb begin
    logic [WAY_W-1:0] hit_way, inv_way, lru_way;
    logic             inv_found;
    hit_c     = 1'b0;
    hit_way   = '0;
    inv_way   = '0;
    lru_way   = '0;
    inv_found = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (mesi_q[idx][w] != MESI_I && tag_q[idx][w] == tag) begin
        hit_c   = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (mesi_q[idx][w] == MESI_I) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[idx][w] == WAY_W'(WAYS-1)) lru_way = WAY_W'(w);
    end
    sel_way_c = hit_c ? hit_way : (inv_found ? inv_way : lru_way);
  end

  mesi_t  nxt_mesi;
  l2_op_t nxt_op;
  logic   nxt_wb;
  mesi_next_state u_mesi (
    .cur (mesi_q[idx][lk_way]),
    .cmd (cmd_q),
    .hit (lk_hit),
    .nxt (nxt_mesi),
    .op  (nxt_op),
    .wb  (nxt_wb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_n == CMD_CLEAR) ? ST_CLEAR : ST_LOOKUP;
      end
      ST_LOOKUP: state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_RESP;
      ST_CLEAR:  if (clr_idx == IDX_W'(SETS-1)) state_nxt = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Arrays, counters and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          mesi_q[s][w] <= MESI_I;
          age_q[s][w]  <= WAY_W'(w);
        end
      hit_count  <= '0;
      miss_count <= '0;
      cmd_q      <= '0;
      line_q     <= '0;
      clr_idx    <= '0;
      lk_hit     <= 1'b0;
      lk_way     <= '0;
      r_hit      <= 1'b0;
      r_way      <= '0;
      r_mesi     <= MESI_I;
      r_op       <= L2_NONE;
      r_wb       <= 1'b0;
      r_wba      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          cmd_q   <= cmd_n;
          line_q  <= cmd_addr[ADDR_W-1:OFFSET_W];
          clr_idx <= '0;
          r_hit   <= 1'b0;
          r_way   <= '0;
          r_mesi  <= MESI_I;
          r_op    <= L2_NONE;
          r_wb    <= 1'b0;
          r_wba   <= '0;
        end
        ST_LOOKUP: begin
          lk_hit <= hit_c;
          lk_way <= sel_way_c;
        end
        ST_UPDATE: begin
          mesi_q[idx][lk_way] <= nxt_mesi;
          r_hit  <= lk_hit && (cmd_q <= 4'd4);
          r_way  <= lk_way;
          r_mesi <= nxt_mesi;
          r_op   <= nxt_op;
          r_wb   <= nxt_wb;
          r_wba  <= {tag_q[idx][lk_way], idx, {OFFSET_W{1'b0}}};
          if (is_access(cmd_q)) begin
            if (!lk_hit) tag_q[idx][lk_way] <= tag;
            for (int w = 0; w < WAYS; w++)
              if (age_q[idx][w] < age_q[idx][lk_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
            age_q[idx][lk_way] <= '0;
            if (lk_hit) hit_count  <= hit_count + 32'd1;
            else        miss_count <= miss_count + 32'd1;
          end
        end
        ST_CLEAR: begin
          for (int w = 0; w < WAYS; w++) begin
            mesi_q[clr_idx][w] <= MESI_I;
            age_q[clr_idx][w]  <= WAY_W'(w);
          end
          hit_count  <= '0;
          miss_count <= '0;
          clr_idx    <= clr_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_hit  = resp_valid & r_hit;
  assign resp_way  = resp_valid ? r_way : '0;
  assign resp_mesi = resp_valid ? r_mesi : MESI_I;
  assign l2_op     = resp_valid ? r_op : L2_NONE;
  assign wb_valid  = resp_valid & r_wb;
  assign wb_addr   = resp_valid ? r_wba : '0;

endmodule
